// File: rtl/regfile_bypass_pkg.sv
// Shared definitions for the architectural register file.
// Holds the default geometry (data width, address width, register count),
// the index of the hardwired zero register and the default forwarding mode.
package regfile_bypass_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_REGS   = 2 ** DEF_ADDR_WIDTH;

    // Register index that always reads as zero and ignores writes.
    localparam int ZERO_REG = 0;

    // 1 = same-cycle write data is forwarded to a matching read port.
    localparam bit DEF_BYPASS = 1'b1;

endpackage

// File: rtl/regfile_bypass_decoder_write.sv
// Enable-gated one-hot decoder for the register file write path.
// Ports:
//   en      - write strobe; when low the output is all-zero
//   addr    - destination register index
//   onehot  - one bit per register, at most one bit set; bit ZERO_REG
//             is always low so the zero register can never be loaded
module regfile_bypass_decoder_write
    import regfile_bypass_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_OUT    = 2 ** ADDR_WIDTH
) (
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_OUT-1:0]    onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        onehot[ZERO_REG] = 1'b0;
    end

endmodule

// File: rtl/regfile_bypass.sv
// Architectural register file: 2**ADDR_WIDTH registers of DATA_WIDTH bits,
// two combinational read ports (A, B) and one synchronous write port.
// Register 0 is hardwired to zero. With BYPASS=1 a write presented in the
// current cycle is forwarded to any read port addressing the same register.
// Ports:
//   clock             - rising-edge clock
//   reset             - asynchronous active-low; clears all registers and
//                       forces both read outputs to zero while low
//   ctrl_writeEnable  - write strobe for the current cycle
//   ctrl_writeReg     - destination register index
//   data_writeReg     - write data
//   ctrl_readRegA/B   - read port source indices
//   data_readRegA/B   - read port data (zero-cycle latency)
module regfile_bypass
    import regfile_bypass_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit BYPASS     = DEF_BYPASS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [NUM_REGS-1:0]   wr_sel;
    logic [NUM_REGS-1:0]   rd_sel_a;
    logic [NUM_REGS-1:0]   rd_sel_b;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] mux_a;
    logic [DATA_WIDTH-1:0] mux_b;
    logic                  wr_live;
    logic                  fwd_a;
    logic                  fwd_b;

    regfile_bypass_decoder_write #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_OUT    (NUM_REGS)
    ) u_decoder_write (
        .en     (ctrl_writeEnable),
        .addr   (ctrl_writeReg),
        .onehot (wr_sel)
    );

    // Storage: one load-enabled, async-cleared word per register. The write
    // decoder never selects register 0, so that word stays at its reset value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= data_writeReg;
                end
            end
        end
    end

    // Read side: one-hot decode of each address feeding an AND-OR mux.
    always_comb begin
        rd_sel_a = '0;
        rd_sel_b = '0;
        mux_a    = '0;
        mux_b    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_sel_a[i] = (ctrl_readRegA == ADDR_WIDTH'(i));
            rd_sel_b[i] = (ctrl_readRegB == ADDR_WIDTH'(i));
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            mux_a = mux_a | (regs[i] & {DATA_WIDTH{rd_sel_a[i]}});
            mux_b = mux_b | (regs[i] & {DATA_WIDTH{rd_sel_b[i]}});
        end
    end

    // A write only "exists" for forwarding when it would actually land on
    // the next edge: out of reset, enabled, and not aimed at register 0.
    assign wr_live = reset && ctrl_writeEnable && (ctrl_writeReg != ZERO_ADDR);
    assign fwd_a   = BYPASS && wr_live && (ctrl_writeReg == ctrl_readRegA);
    assign fwd_b   = BYPASS && wr_live && (ctrl_writeReg == ctrl_readRegB);

    // Outputs are forced to zero while reset is low, independent of the
    // storage clear, so nothing leaks through the forwarding path.
    assign data_readRegA = !reset ? '0 : (fwd_a ? data_writeReg : mux_a);
    assign data_readRegB = !reset ? '0 : (fwd_b ? data_writeReg : mux_b);

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass. Two instances share all inputs: one
// with forwarding enabled (b1) and one with it disabled (b0).
module tb_regfile_bypass;

    logic        clock;
    logic        reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] a_b1, b_b1, a_b0, b_b0;

    int tests_run    = 0;
    int tests_failed = 0;

    regfile_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut_b1 (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (a_b1),
        .data_readRegB    (b_b1)
    );

    regfile_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_b0 (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (a_b0),
        .data_readRegB    (b_b0)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled here, well away from the following edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Single-edge write, strobe dropped afterwards.
    task automatic drive_write(input logic [4:0] r, input logic [31:0] d);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = r;
        data_writeReg    = d;
        step();
        ctrl_writeEnable = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg = 5'd0;
        data_writeReg = 32'h0;
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd31;
        step();
        tests_run++;
        if ({a_b1, b_b1, a_b0, b_b0} !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got %h %h %h %h exp 0", a_b1, b_b1, a_b0, b_b0);
        end
        reset = 1'b1;
        step();
        drive_write(5'd5, 32'hDEADBEEF);
        tests_run++;
        if ({a_b1, a_b0} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL reset_prewrite got %h %h exp deadbeef", a_b1, a_b0);
        end
        // Mid-cycle asynchronous reset, no clock edge in between.
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if ({a_b1, a_b0} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_async_clear got %h %h exp 0", a_b1, a_b0);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({a_b1, a_b0} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_after_release got %h %h exp 0", a_b1, a_b0);
        end
        step();
        step();
        tests_run++;
        if ({a_b1, a_b0} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_stays_clear got %h %h exp 0", a_b1, a_b0);
        end
    endtask

    task automatic test_basic();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg = 5'd7;
        data_writeReg = 32'h12345678;
        step();
        ctrl_writeReg = 5'd31;
        data_writeReg = 32'hCAFEF00D;
        step();
        ctrl_writeEnable = 1'b0;
        ctrl_readRegA = 5'd7;
        ctrl_readRegB = 5'd31;
        #1;
        tests_run++;
        if ({a_b1, b_b1, a_b0, b_b0} !== {32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D}) begin
            tests_failed++;
            $display("FAIL basic_rw got %h %h %h %h exp 12345678 cafef00d", a_b1, b_b1, a_b0, b_b0);
        end
        // Swap ports to exercise the other mux.
        ctrl_readRegA = 5'd31;
        ctrl_readRegB = 5'd7;
        #1;
        tests_run++;
        if ({a_b1, b_b1} !== {32'hCAFEF00D, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL basic_swap got %h %h exp cafef00d 12345678", a_b1, b_b1);
        end
    endtask

    task automatic test_reg0();
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg = 5'd0;
        data_writeReg = 32'hFFFFFFFF;
        #1;
        tests_run++;
        if ({a_b1, b_b1, a_b0, b_b0} !== 128'h0) begin
            tests_failed++;
            $display("FAIL reg0_before_edge got %h %h %h %h exp 0", a_b1, b_b1, a_b0, b_b0);
        end
        step();
        ctrl_writeEnable = 1'b0;
        #1;
        tests_run++;
        if ({a_b1, b_b1, a_b0, b_b0} !== 128'h0) begin
            tests_failed++;
            $display("FAIL reg0_after_edge got %h %h %h %h exp 0", a_b1, b_b1, a_b0, b_b0);
        end
    endtask

    task automatic test_bypass();
        drive_write(5'd3, 32'h00000001);
        ctrl_readRegA = 5'd3;
        ctrl_readRegB = 5'd3;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg = 5'd3;
        data_writeReg = 32'hABCD0000;
        #1;
        tests_run++;
        if ({a_b1, b_b1} !== {32'hABCD0000, 32'hABCD0000}) begin
            tests_failed++;
            $display("FAIL bypass_fwd got %h %h exp abcd0000", a_b1, b_b1);
        end
        tests_run++;
        if ({a_b0, b_b0} !== {32'h1, 32'h1}) begin
            tests_failed++;
            $display("FAIL bypass_off_old got %h %h exp 00000001", a_b0, b_b0);
        end
        step();
        ctrl_writeEnable = 1'b0;
        #1;
        tests_run++;
        if ({a_b1, b_b1, a_b0, b_b0} !== {4{32'hABCD0000}}) begin
            tests_failed++;
            $display("FAIL bypass_after_edge got %h %h %h %h exp abcd0000", a_b1, b_b1, a_b0, b_b0);
        end
    endtask

    // Forwarding on one port only: A reads r7 (stored), B reads r31 (written).
    task automatic test_independent_ports();
        ctrl_readRegA = 5'd7;
        ctrl_readRegB = 5'd31;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg = 5'd31;
        data_writeReg = 32'h0BADC0DE;
        #1;
        tests_run++;
        if ({a_b1, b_b1, a_b0, b_b0} !== {32'h12345678, 32'h0BADC0DE, 32'h12345678, 32'hCAFEF00D}) begin
            tests_failed++;
            $display("FAIL indep_ports got %h %h %h %h exp 12345678 0badc0de 12345678 cafef00d",
                     a_b1, b_b1, a_b0, b_b0);
        end
        step();
        ctrl_writeEnable = 1'b0;
        #1;
    endtask

    task automatic test_enable_gating();
        ctrl_readRegA = 5'd9;
        ctrl_readRegB = 5'd9;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg = 5'd9;
        data_writeReg = 32'h55AA55AA;
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if ({a_b1, b_b0} !== 64'h0) begin
                tests_failed++;
                $display("FAIL enable_gated_%0d got %h %h exp 0", k, a_b1, b_b0);
            end
        end
        drive_write(5'd9, 32'h55AA55AA);
        tests_run++;
        if ({a_b1, b_b1, a_b0, b_b0} !== {4{32'h55AA55AA}}) begin
            tests_failed++;
            $display("FAIL enable_write got %h %h %h %h exp 55aa55aa", a_b1, b_b1, a_b0, b_b0);
        end
    endtask

    task automatic test_write_during_reset();
        ctrl_readRegA = 5'd12;
        ctrl_readRegB = 5'd12;
        reset = 1'b0;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg = 5'd12;
        data_writeReg = 32'h00000077;
        #1;
        tests_run++;
        if ({a_b1, b_b1, a_b0, b_b0} !== 128'h0) begin
            tests_failed++;
            $display("FAIL wr_in_reset_outputs got %h %h %h %h exp 0", a_b1, b_b1, a_b0, b_b0);
        end
        step();
        reset = 1'b1;
        #1;
        // Stored r12 must still be zero; only the forwarding path shows 0x77.
        tests_run++;
        if ({a_b0, b_b0, a_b1} !== {32'h0, 32'h0, 32'h77}) begin
            tests_failed++;
            $display("FAIL wr_in_reset_release got %h %h %h exp 0 0 77", a_b0, b_b0, a_b1);
        end
        step();
        ctrl_writeEnable = 1'b0;
        #1;
        tests_run++;
        if ({a_b1, b_b1, a_b0, b_b0} !== {4{32'h77}}) begin
            tests_failed++;
            $display("FAIL wr_after_release got %h %h %h %h exp 77", a_b1, b_b1, a_b0, b_b0);
        end
        // Earlier registers were wiped by that reset.
        ctrl_readRegA = 5'd7;
        ctrl_readRegB = 5'd9;
        #1;
        tests_run++;
        if ({a_b1, b_b1, a_b0, b_b0} !== 128'h0) begin
            tests_failed++;
            $display("FAIL wr_in_reset_others got %h %h %h %h exp 0", a_b1, b_b1, a_b0, b_b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reg0();
        test_bypass();
        test_independent_ports();
        test_enable_gating();
        test_write_during_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
